// File: rtl/weather_sensor_conditioner_if.sv
// weather_sensor_conditioner_if
// Groups the raw sample bus and the conditioned output bus of the weather sensor conditioner.
//   master : drives sample_valid/raw_* and observes the conditioned outputs (producer side)
//   slave  : consumes sample_valid/raw_* and drives the conditioned outputs (conditioner side)
// Signals:
//   sample_valid  - raw inputs valid, one sample accepted per high cycle
//   raw_wind      - wind speed, knots, unsigned
//   raw_temp      - temperature, signed, 0.5 degC units
//   raw_vis_m     - visibility range, metres, unsigned
//   raw_lightning - lightning detected in this sample
//   wind          - conditioned wind, knots
//   temperature   - conditioned temperature, signed degC
//   visibility    - class 0 clear .. 3 very poor
//   thunderstorm  - lightning activity present
//   data_valid    - conditioned outputs trustworthy
//   sensor_fault  - sample stream stale
interface weather_sensor_conditioner_if;
    logic        sample_valid;
    logic [7:0]  raw_wind;
    logic [9:0]  raw_temp;
    logic [13:0] raw_vis_m;
    logic        raw_lightning;
    logic [5:0]  wind;
    logic [7:0]  temperature;
    logic [1:0]  visibility;
    logic        thunderstorm;
    logic        data_valid;
    logic        sensor_fault;

    modport master (
        output sample_valid, raw_wind, raw_temp, raw_vis_m, raw_lightning,
        input  wind, temperature, visibility, thunderstorm, data_valid, sensor_fault
    );

    modport slave (
        input  sample_valid, raw_wind, raw_temp, raw_vis_m, raw_lightning,
        output wind, temperature, visibility, thunderstorm, data_valid, sensor_fault
    );
endinterface

// File: rtl/weather_sensor_conditioner.sv
// weather_sensor_conditioner
// Conditions raw airfield weather samples: 4-sample wind window, temperature rescale/clamp,
// visibility classification with a two-sample confirmation filter, lightning hold stretch,
// warm-up qualification and stale-stream detection. All outputs registered, 1-cycle latency.
// Ports:
//   CLK - clock, rising edge
//   RST - synchronous active-low reset
//   bus - weather_sensor_conditioner_if.slave (raw sample in, conditioned outputs out)
// Parameters:
//   HOLD_SAMPLES   - strike-free accepted samples before thunderstorm drops (1..255)
//   TIMEOUT_CYCLES - idle cycles before sensor_fault asserts (1..65535)
// Build option:
//   WSC_WIND_GUST_EN - when defined, wind reports the window maximum instead of the average.
module weather_sensor_conditioner #(
    parameter int unsigned HOLD_SAMPLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                          CLK,
    input logic                          RST,
    weather_sensor_conditioner_if.slave  bus
);

    localparam logic [7:0]  HoldInit   = 8'(HOLD_SAMPLES);
    localparam logic [15:0] TimeoutMax = 16'(TIMEOUT_CYCLES);

    logic [7:0]  win_q [4];
    logic [7:0]  win_d [4];
    logic [2:0]  sample_cnt_q;
    logic [7:0]  hold_q;
    logic [15:0] tmo_q;
    logic [1:0]  cand_q;
    logic        cand_vld_q;

    logic [5:0]  wind_q;
    logic [7:0]  temp_q;
    logic [1:0]  vis_q;
    logic        ts_q;
    logic        dv_q;
    logic        fault_q;

    logic [7:0]        wind_pre;
    logic [5:0]        wind_d;
    logic signed [8:0] temp_half;
    logic [7:0]        temp_d;
    logic [1:0]        vis_cls;

    assign bus.wind         = wind_q;
    assign bus.temperature  = temp_q;
    assign bus.visibility   = vis_q;
    assign bus.thunderstorm = ts_q;
    assign bus.data_valid   = dv_q;
    assign bus.sensor_fault = fault_q;

    // Window as it will look after the current sample is shifted in.
    always_comb begin
        win_d[0] = bus.raw_wind;
        win_d[1] = win_q[0];
        win_d[2] = win_q[1];
        win_d[3] = win_q[2];
    end

`ifdef WSC_WIND_GUST_EN
    always_comb begin
        wind_pre = win_d[0];
        for (int i = 1; i < 4; i++) begin
            if (win_d[i] > wind_pre) wind_pre = win_d[i];
        end
    end
`else
    logic [9:0] wind_sum;
    always_comb begin
        wind_sum = 10'(win_d[0]) + 10'(win_d[1]) + 10'(win_d[2]) + 10'(win_d[3]);
        wind_pre = wind_sum[9:2];
    end
`endif

    always_comb begin
        wind_d = (wind_pre > 8'd63) ? 6'd63 : wind_pre[5:0];

        // Dropping the LSB of a two's complement value is the floor halving.
        temp_half = $signed(bus.raw_temp[9:1]);
        if (temp_half > 9'sd127) begin
            temp_d = 8'h7f;
        end else if (temp_half < -9'sd128) begin
            temp_d = 8'h80;
        end else begin
            temp_d = temp_half[7:0];
        end

        if (bus.raw_vis_m >= 14'd5000) begin
            vis_cls = 2'd0;
        end else if (bus.raw_vis_m >= 14'd1500) begin
            vis_cls = 2'd1;
        end else if (bus.raw_vis_m >= 14'd500) begin
            vis_cls = 2'd2;
        end else begin
            vis_cls = 2'd3;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 4; i++) win_q[i] <= '0;
            sample_cnt_q <= '0;
            hold_q       <= '0;
            tmo_q        <= '0;
            cand_q       <= '0;
            cand_vld_q   <= 1'b0;
            wind_q       <= '0;
            temp_q       <= '0;
            vis_q        <= '0;
            ts_q         <= 1'b0;
            dv_q         <= 1'b0;
            fault_q      <= 1'b0;
        end else if (bus.sample_valid) begin
            // A sample always wins over a coincident timeout expiry.
            for (int i = 0; i < 4; i++) win_q[i] <= win_d[i];
            wind_q <= wind_d;
            temp_q <= temp_d;

            if (sample_cnt_q == 3'd0) begin
                vis_q      <= vis_cls;
                cand_vld_q <= 1'b0;
            end else if (vis_cls == vis_q) begin
                cand_vld_q <= 1'b0;
            end else if (cand_vld_q && (cand_q == vis_cls)) begin
                vis_q      <= vis_cls;
                cand_vld_q <= 1'b0;
            end else begin
                cand_q     <= vis_cls;
                cand_vld_q <= 1'b1;
            end

            if (bus.raw_lightning) begin
                hold_q <= HoldInit;
                ts_q   <= 1'b1;
            end else if (hold_q != 8'd0) begin
                hold_q <= hold_q - 8'd1;
                if (hold_q == 8'd1) ts_q <= 1'b0;
            end

            if (sample_cnt_q != 3'd4) sample_cnt_q <= sample_cnt_q + 3'd1;
            dv_q    <= (sample_cnt_q >= 3'd3);
            fault_q <= 1'b0;
            tmo_q   <= '0;
        end else if (tmo_q != TimeoutMax) begin
            tmo_q <= tmo_q + 16'd1;
            if (tmo_q + 16'd1 == TimeoutMax) begin
                fault_q <= 1'b1;
                dv_q    <= 1'b0;
            end
        end
    end

endmodule
